freq_meter: RTL and testbench

- Gated frequency counter that consumes a slow periodic signal, such as the output of the team's clock dividers, and reports rising edges per fixed gate window measured in system-clock cycles.
- Sits beside the divider blocks as their checker and measurement end.
- Used on-board to verify divided clocks and to measure external slow signals: buttons, sensors, an external generator.

---
 rtl/freq_meter_pkg.sv | 30 +++
 rtl/edge_sync.sv | 29 ++
 rtl/freq_meter.sv | 108 ++++++++++
 tb/tb_freq_meter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fm_state_t;

    // Widest counter the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Add inc to cnt, clamping at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] cnt,
        input logic                 inc,
        input int                   w
    );
        logic [SAT_MAX_W-1:0] max_v;
        if (w >= SAT_MAX_W) begin
            max_v = {SAT_MAX_W{1'b1}};
        end else begin
            max_v = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
        end
        if (inc && (cnt < max_v)) begin
            return cnt + SAT_MAX_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a history flop,
// producing a one-cycle pulse on each synchronized rising edge.
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the raw input through the metastability flops and the edge flop.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// fixed windows of GATE_CYCLES clocks and publishes the saturated count.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic             sig_rise,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    fm_state_t         r_state;
    fm_state_t         w_state_nxt;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_window_sat;
    logic [CNT_W-1:0]  r_freq_out;
    logic              r_freq_valid;
    logic              r_overflow;

    logic              w_rise;
    logic              w_win_end;
    logic              w_sat_hit;
    logic [CNT_W-1:0]  w_edge_next;

    edge_sync u_edge_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (sig_in),
        .rise   (w_rise)
    );

    // Last cycle of the gate window; en is ignored here so the window completes.
    assign w_win_end   = (r_state == MEASURE) && (r_gate_cnt == GATE_LAST);
    // A rise arriving while the counter is already pinned marks the window saturated.
    assign w_sat_hit   = w_rise && (r_edge_cnt == CNT_MAX);
    assign w_edge_next = CNT_W'(sat_inc(SAT_MAX_W'(r_edge_cnt), w_rise, CNT_W));

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: en starts measuring; losing en (abort or window end) returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en)  w_state_nxt = MEASURE;
            MEASURE: if (!en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gate and edge counters: advance mid-window, otherwise held at zero.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_window_sat <= 1'b0;
        end else if ((r_state == MEASURE) && en && !w_win_end) begin
            r_gate_cnt   <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt   <= w_edge_next;
            r_window_sat <= r_window_sat | w_sat_hit;
        end else begin
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_window_sat <= 1'b0;
        end
    end

    // Result registers: publish the count (including this cycle's rise) at window end.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_freq_out   <= '0;
            r_overflow   <= 1'b0;
            r_freq_valid <= 1'b0;
        end else begin
            r_freq_valid <= w_win_end;
            if (w_win_end) begin
                r_freq_out <= w_edge_next;
                r_overflow <= r_window_sat | w_sat_hit;
            end
        end
    end

    assign sig_rise   = w_rise;
    assign freq_out   = r_freq_out;
    assign freq_valid = r_freq_valid;
    assign overflow   = r_overflow;
    assign busy       = (r_state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed scenarios plus randomized segments, all
// checked cycle by cycle against a window-level edge-counting model.
module tb_freq_meter;

    localparam int G     = 100;
    localparam int CW    = 4;
    localparam int MAXV  = (1 << CW) - 1;
    localparam int MAXE  = 32768;

    logic          clk_in;
    logic          rst;
    logic          en;
    logic          sig_in = 1'b1;
    logic          sig_rise;
    logic [CW-1:0] freq_out;
    logic          freq_valid;
    logic          overflow;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Stimulus generator settings (0: hold level, 1: periodic, 2: random toggles)
    int   gen_mode  = 0;
    logic gen_level = 1'b1;
    int   gen_per   = 10;
    int   gen_ph    = 0;
    int   gcyc      = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .sig_rise   (sig_rise),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Drive sig_in shortly after each falling edge.
    always @(negedge clk_in) begin
        #1;
        gcyc++;
        case (gen_mode)
            0: sig_in = gen_level;
            1: sig_in = (((gcyc + gen_ph) % gen_per) < (gen_per / 2));
            default: if ($urandom_range(0, gen_per - 1) == 0) sig_in = ~sig_in;
        endcase
    end

    // Reference model: sampled history of sig_in, windows tracked by start edge.
    bit   hist [MAXE];
    int   n_edge   = -1;
    int   last_rst = -1;
    bit   m_active = 0;
    int   m_start  = 0;
    int   m_count  = 0;
    bit   chk_on   = 0;
    int   e_freq   = 0;
    bit   e_ovf    = 0;
    bit   e_valid  = 0;
    bit   e_rise   = 0;
    bit   e_busy   = 0;

    function automatic bit h(input int k);
        if (k < 0 || k <= last_rst || k >= MAXE) return 1'b0;
        return hist[k];
    endfunction

    always @(posedge clk_in) begin
        bit r;
        n_edge++;
        if (rst) begin
            last_rst = n_edge;
            m_active = 0;
            e_freq   = 0;
            e_ovf    = 0;
            e_valid  = 0;
            chk_on   = 1;
        end else begin
            if (n_edge < MAXE) hist[n_edge] = sig_in;
            e_valid = 0;
            // synchronized rise seen by the counter at this edge: 0->1 two samples back
            r = h(n_edge - 2) & ~h(n_edge - 3);
            if (m_active) begin
                m_count += int'(r);
                if (n_edge == m_start + G) begin
                    e_freq  = (m_count > MAXV) ? MAXV : m_count;
                    e_ovf   = (m_count > MAXV);
                    e_valid = 1;
                    if (en) begin
                        m_start = n_edge;
                        m_count = 0;
                    end else begin
                        m_active = 0;
                    end
                end else if (!en) begin
                    m_active = 0;
                end
            end else if (en) begin
                m_active = 1;
                m_start  = n_edge;
                m_count  = 0;
            end
        end
        e_rise = h(n_edge - 1) & ~h(n_edge - 2);
        e_busy = m_active;
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk_in) begin
        if (chk_on) begin
            chk("sig_rise",   sig_rise,   e_rise);
            chk("busy",       busy,       e_busy);
            chk("freq_valid", freq_valid, e_valid);
            chk("freq_out",   freq_out,   e_freq);
            chk("overflow",   overflow,   e_ovf);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk_in);
        #2;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_in);
            cnt++;
        end while (!freq_valid && cnt < budget);
        if (!freq_valid) chk("valid_timeout", freq_valid, 1);
        #2;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b1;
        step(3);
        rst = 1'b0;

        // sig_in high since before reset: one rise, counted once
        wait_valid(150, n);
        chk("const_first", freq_out, 1);
        wait_valid(150, n);
        chk("const_next", freq_out, 0);
        chk("const_ovf", overflow, 0);

        // periodic input, period 10
        gen_ph   = $urandom_range(0, 9);
        gen_per  = 10;
        gen_mode = 1;
        wait_valid(150, n);
        repeat (3) begin
            wait_valid(150, n);
            chk("per10_lat", n, G);
            chk("per10_freq", freq_out, 10);
            chk("per10_busy", busy, 1);
        end

        // saturation, then recovery
        gen_per = 4;
        wait_valid(150, n);
        wait_valid(150, n);
        chk("sat_freq", freq_out, 15);
        chk("sat_ovf", overflow, 1);
        gen_per = 20;
        wait_valid(150, n);
        wait_valid(150, n);
        chk("slow_freq", freq_out, 5);
        chk("slow_ovf", overflow, 0);

        // abort mid-window
        gen_per = 10;
        wait_valid(150, n);
        wait_valid(150, n);
        chk("abort_pre", freq_out, 10);
        step(50);
        en = 1'b0;
        step(1);
        chk("abort_busy", busy, 0);
        step(30);
        chk("abort_hold", freq_out, 10);
        en = 1'b1;
        wait_valid(200, n);
        chk("abort_restart_lat", n, G + 1);
        chk("abort_restart_freq", freq_out, 10);

        // single rise landing on the last gate cycle
        gen_mode  = 0;
        gen_level = 1'b0;
        wait_valid(150, n);
        wait_valid(150, n);
        step(G - 4);
        gen_level = 1'b1;
        wait_valid(150, n);
        chk("bound_lat", n, 4);
        chk("bound_freq", freq_out, 1);
        wait_valid(150, n);
        chk("bound_next", freq_out, 0);

        // reset mid-window
        gen_mode = 1;
        wait_valid(150, n);
        wait_valid(150, n);
        chk("rstmid_pre", freq_out, 10);
        step(40);
        rst = 1'b1;
        step(1);
        chk("rstmid_freq", freq_out, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", freq_valid, 0);
        rst = 1'b0;
        step(1);
        chk("rstmid_resume", busy, 1);

        // randomized segments
        for (int s = 0; s < 25; s++) begin
            gen_per  = $urandom_range(2, 40);
            gen_ph   = $urandom_range(0, 39);
            gen_mode = ($urandom_range(0, 2) == 0) ? 2 : 1;
            en       = ($urandom_range(0, 4) != 0);
            rst      = ($urandom_range(0, 7) == 0);
            if (rst) begin
                step(1);
                rst = 1'b0;
            end
            step($urandom_range(20, 260));
        end
        en  = 1'b1;
        rst = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
